// File: rtl/mxfp8_pkg.sv
// MX shared types: data-type and ALU op encodings, result bundle, size helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mxfp8_pkg;

  typedef enum logic [2:0] {
    MX_E4M3 = 3'd0,
    MX_E5M2 = 3'd1,
    MX_E3M2 = 3'd2,
    MX_E2M3 = 3'd3,
    MX_E2M1 = 3'd4,
    MX_INT8 = 3'd5
  } mx_dtype_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_MUL   = 3'd2,
    ALU_MAX   = 3'd3,
    ALU_MIN   = 3'd4,
    ALU_AND   = 3'd5,
    ALU_XOR   = 3'd6,
    ALU_BCAST = 3'd7
  } mx_alu_op_e;

  localparam int MX_D_DEF     = 8;
  localparam int MX_K_DEF     = 32;
  localparam int MX_W_DEF     = 8;
  localparam int MX_TAG_W_DEF = 4;

  // Block size: shared scale on top, k elements of d bits below it.
  function automatic int mx_size(input int d, input int k, input int w);
    return w + k * d;
  endfunction

  localparam int MX_SIZE_DEF = MX_W_DEF + MX_K_DEF * MX_D_DEF;

  // Result bundle at the default block geometry.
  typedef struct packed {
    logic [MX_SIZE_DEF-1:0]  vec;
    logic [31:0]             scalar;
    logic [MX_TAG_W_DEF-1:0] tag;
  } mx_alu_res_s;

endpackage

// File: rtl/mx_alu.sv
// Combinational MX vector ALU: element-wise op on two blocks plus scalar reduction.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers inputs/outputs.
// Ports: dtype_i/op_i select format and op; scalar_i, vec_a_i, vec_b_i operands;
//        vec_o = {max(scale_a, scale_b), per-element result};
//        scalar_o = scalar_i + sum(result elements) + dtype_i.
module mx_alu
  import mxfp8_pkg::*;
#(
  parameter int d = 8,
  parameter int k = 32,
  parameter int w = 8
) (
  input  logic [2:0]         dtype_i,
  input  logic [2:0]         op_i,
  input  logic [31:0]        scalar_i,
  input  logic [w+k*d-1:0]   vec_a_i,
  input  logic [w+k*d-1:0]   vec_b_i,
  output logic [w+k*d-1:0]   vec_o,
  output logic [31:0]        scalar_o
);

  localparam int SIZE = w + k * d;

  logic [d-1:0] ea, eb, er;
  logic [31:0]  sum;

  always_comb begin
    vec_o = '0;
    sum   = '0;
    ea    = '0;
    eb    = '0;
    er    = '0;
    vec_o[SIZE-1 -: w] = (vec_a_i[SIZE-1 -: w] >= vec_b_i[SIZE-1 -: w]) ?
                         vec_a_i[SIZE-1 -: w] : vec_b_i[SIZE-1 -: w];
    for (int i = 0; i < k; i++) begin
      ea = vec_a_i[i*d +: d];
      eb = vec_b_i[i*d +: d];
      unique case (mx_alu_op_e'(op_i))
        ALU_ADD: er = ea + eb;
        ALU_SUB: er = ea - eb;
        ALU_MUL: er = ea * eb;
        ALU_MAX: er = (ea > eb) ? ea : eb;
        ALU_MIN: er = (ea < eb) ? ea : eb;
        ALU_AND: er = ea & eb;
        ALU_XOR: er = ea ^ eb;
        default: er = scalar_i[d-1:0];
      endcase
      vec_o[i*d +: d] = er;
      sum = sum + 32'(er);
    end
    // dtype only salts the scalar result in this integer datapath.
    scalar_o = scalar_i + sum + 32'(dtype_i);
  end

endmodule

// File: rtl/mx_alu_pipe_fifo.sv
// Circular result FIFO, DEPTH entries (any DEPTH >= 2, not just powers of two).
// Latency: write visible at head on the next cycle.
// Backpressure: none internally; the writer guarantees no write when full.
// Ports: clk, reset (sync, active-high), wr_i/wdata_i write, pop_i pops head,
//        rdata_o head entry, empty_o/full_o occupancy flags.
module mx_alu_pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_i)   wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(wr_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mx_alu_pipe.sv
// Pipelined valid/ready wrapper around mx_alu with tag passthrough and credit-protected output FIFO.
// Latency: accept in cycle t -> v_o in cycle t+LAT+1 (input reg, LAT-1 stage regs, FIFO entry).
// Backpressure: ready_o from registered credits only; pipeline never stalls, FIFO absorbs results.
// Ports: clk, reset (sync, active-high); v_i/ready_o + dtype_i, op_i, tag_i, scalar_i,
//        vec_a_i, vec_b_i in; v_o/ready_i + vec_o, scalar_o, tag_o out (zero when v_o=0).
// Optional: define MX_ALU_PIPE_STATS_EN to add stat_ops_o (accepts) and stat_stall_o
//           (cycles with v_i && !ready_o), both 32-bit wrapping counters.
module mx_alu_pipe
  import mxfp8_pkg::*;
#(
  parameter int d     = 8,
  parameter int k     = 32,
  parameter int w     = 8,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [2:0]         dtype_i,
  input  logic [2:0]         op_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic [31:0]        scalar_i,
  input  logic [w+k*d-1:0]   vec_a_i,
  input  logic [w+k*d-1:0]   vec_b_i,
  output logic               v_o,
  input  logic               ready_i,
  output logic [w+k*d-1:0]   vec_o,
  output logic [31:0]        scalar_o,
  output logic [TAG_W-1:0]   tag_o
`ifdef MX_ALU_PIPE_STATS_EN
  ,
  output logic [31:0]        stat_ops_o,
  output logic [31:0]        stat_stall_o
`endif
);

  localparam int SIZE = mx_size(d, k, w);
  localparam int CW   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [SIZE-1:0]  vec;
    logic [31:0]      scalar;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic             accept, pop;
  logic [CW-1:0]    credits_q, credits_d;

  logic             in_v_q;
  logic [2:0]       in_dtype_q, in_op_q;
  logic [TAG_W-1:0] in_tag_q;
  logic [31:0]      in_scalar_q;
  logic [SIZE-1:0]  in_a_q, in_b_q;

  res_t             alu_res, wr_res, head;
  logic             wr_v;
  logic             fifo_empty, fifo_full;

  // Credits count free result slots; they depend on registered state and reset only.
  assign ready_o = (credits_q != '0) && !reset;
  assign accept  = v_i && ready_o;
  assign v_o     = !fifo_empty && !reset;
  assign pop     = v_o && ready_i;

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop)      credits_d = credits_q - CW'(1);
    else if (pop && !accept) credits_d = credits_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= CW'(DEPTH);
      in_v_q    <= 1'b0;
    end else begin
      credits_q <= credits_d;
      in_v_q    <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      in_dtype_q  <= dtype_i;
      in_op_q     <= op_i;
      in_tag_q    <= tag_i;
      in_scalar_q <= scalar_i;
      in_a_q      <= vec_a_i;
      in_b_q      <= vec_b_i;
    end
  end

  mx_alu #(
    .d(d),
    .k(k),
    .w(w)
  ) u_alu (
    .dtype_i  (in_dtype_q),
    .op_i     (in_op_q),
    .scalar_i (in_scalar_q),
    .vec_a_i  (in_a_q),
    .vec_b_i  (in_b_q),
    .vec_o    (alu_res.vec),
    .scalar_o (alu_res.scalar)
  );
  assign alu_res.tag = in_tag_q;

  // The FIFO write is the last of the LAT stages, so only LAT-1 registers sit in between.
  generate
    if (LAT == 1) begin : g_lat1
      assign wr_v   = in_v_q;
      assign wr_res = alu_res;
    end else begin : g_latn
      logic [LAT-2:0] stg_v_q;
      res_t           stg_res_q [LAT-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          stg_v_q <= '0;
        end else begin
          stg_v_q[0] <= in_v_q;
          for (int i = 1; i < LAT - 1; i++) stg_v_q[i] <= stg_v_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (in_v_q) stg_res_q[0] <= alu_res;
        for (int i = 1; i < LAT - 1; i++) begin
          if (stg_v_q[i-1]) stg_res_q[i] <= stg_res_q[i-1];
        end
      end

      assign wr_v   = stg_v_q[LAT-2];
      assign wr_res = stg_res_q[LAT-2];
    end
  endgenerate

  mx_alu_pipe_fifo #(
    .WIDTH($bits(res_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (wr_v),
    .wdata_i (wr_res),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Credits reserve a FIFO slot at accept time, so a write can never find it full.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr_v && fifo_full));

  assign vec_o    = v_o ? head.vec    : '0;
  assign scalar_o = v_o ? head.scalar : '0;
  assign tag_o    = v_o ? head.tag    : '0;

`ifdef MX_ALU_PIPE_STATS_EN
  logic [31:0] stat_ops_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      if (accept)          stat_ops_q   <= stat_ops_q + 32'd1;
      if (v_i && !ready_o) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_ops_o   = stat_ops_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_mx_alu_pipe.sv
// Self-checking bench for mx_alu_pipe at d=8, k=32, w=8, LAT=2, DEPTH=4.
// Expected results come from an independent ALU model pushed to a scoreboard on accept.
// Output monitor pops the scoreboard on every v_o && ready_i and checks masking otherwise.
module tb_mx_alu_pipe;
  import mxfp8_pkg::*;

  localparam int D = 8, K = 32, W = 8, LAT = 2, DEPTH = 4, TAG_W = 4;
  localparam int SIZE = W + K * D;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             v_i = 1'b0;
  logic             ready_i = 1'b0;
  logic [2:0]       dtype_i = '0;
  logic [2:0]       op_i = '0;
  logic [TAG_W-1:0] tag_i = '0;
  logic [31:0]      scalar_i = '0;
  logic [SIZE-1:0]  vec_a_i = '0;
  logic [SIZE-1:0]  vec_b_i = '0;
  logic             ready_o, v_o;
  logic [SIZE-1:0]  vec_o;
  logic [31:0]      scalar_o;
  logic [TAG_W-1:0] tag_o;
`ifdef MX_ALU_PIPE_STATS_EN
  logic [31:0]      stat_ops_o, stat_stall_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  mx_alu_res_s sb_q[$];

  always #5 clk = ~clk;

  mx_alu_pipe #(
    .d(D), .k(K), .w(W), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .dtype_i  (dtype_i),
    .op_i     (op_i),
    .tag_i    (tag_i),
    .scalar_i (scalar_i),
    .vec_a_i  (vec_a_i),
    .vec_b_i  (vec_b_i),
    .v_o      (v_o),
    .ready_i  (ready_i),
    .vec_o    (vec_o),
    .scalar_o (scalar_o),
    .tag_o    (tag_o)
`ifdef MX_ALU_PIPE_STATS_EN
    ,
    .stat_ops_o   (stat_ops_o),
    .stat_stall_o (stat_stall_o)
`endif
  );

  task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  function automatic mx_alu_res_s model(input logic [2:0] dt, input logic [2:0] opc,
                                        input logic [31:0] sc, input logic [SIZE-1:0] a,
                                        input logic [SIZE-1:0] b, input logic [TAG_W-1:0] tg);
    mx_alu_res_s r;
    logic [7:0]  x, y, z;
    logic [31:0] acc;
    r.vec = '0;
    acc   = sc + {29'd0, dt};
    r.vec[SIZE-1 -: 8] = (a[SIZE-1 -: 8] >= b[SIZE-1 -: 8]) ? a[SIZE-1 -: 8] : b[SIZE-1 -: 8];
    for (int i = 0; i < K; i++) begin
      x = a[i*8 +: 8];
      y = b[i*8 +: 8];
      case (opc)
        3'd0:    z = x + y;
        3'd1:    z = x - y;
        3'd2:    z = x * y;
        3'd3:    z = (x > y) ? x : y;
        3'd4:    z = (x < y) ? x : y;
        3'd5:    z = x & y;
        3'd6:    z = x ^ y;
        default: z = sc[7:0];
      endcase
      r.vec[i*8 +: 8] = z;
      acc = acc + {24'd0, z};
    end
    r.scalar = acc;
    r.tag    = tg;
    return r;
  endfunction

  task automatic set_op(input logic [TAG_W-1:0] tg, input logic [2:0] opc);
    dtype_i  = 3'($urandom_range(0, 5));
    op_i     = opc;
    tag_i    = tg;
    scalar_i = $urandom;
    for (int i = 0; i < SIZE / 8; i++) begin
      vec_a_i[i*8 +: 8] = 8'($urandom);
      vec_b_i[i*8 +: 8] = 8'($urandom);
    end
  endtask

  // One cycle: note whether the current input is accepted, then move past the edge.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = v_i && ready_o;
    if (acc) sb_q.push_back(model(dtype_i, op_i, scalar_i, vec_a_i, vec_b_i, tag_i));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_i = 1'b1;
    v_i     = 1'b0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output monitor.
  always @(negedge clk) begin
    mx_alu_res_s e;
    if (v_o) begin
      if (ready_i) begin
        check("result_expected", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("vec", vec_o, e.vec);
          check("scalar", scalar_o, e.scalar);
          check("tag", tag_o, e.tag);
        end
      end
    end else begin
      check("masked_out", {vec_o, scalar_o, tag_o}, '0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit acc;
    int idx;
    int cnt;
    bit acc_hist [8];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready_o, 1'b0);
    check("rst_v", v_o, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("first_ready", ready_o, 1'b1);
    @(posedge clk);
    #1;

    // Single op, tag 5
    ready_i = 1'b1;
    v_i = 1'b1;
    set_op(4'd5, 3'd0);
    step(acc);
    check("s1_acc", acc, 1'b1);
    v_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("s1_latency", v_o, i == 3);
      if (i == 3) check("s1_tag", tag_o, 4'd5);
      @(posedge clk);
      #1;
    end
    drain();

    // Back-pressure: v_i held, ready_i low
    ready_i = 1'b0;
    idx = 0;
    v_i = 1'b1;
    set_op(4'(idx), 3'($urandom_range(0, 7)));
    for (int c = 0; c < 6; c++) begin
      step(acc);
      check("bp_ready", acc, c < 4);
      if (acc) begin
        idx++;
        set_op(4'(idx), 3'($urandom_range(0, 7)));
      end
    end
`ifdef MX_ALU_PIPE_STATS_EN
    check("bp_stall_cnt", stat_stall_o, 32'd2);
    check("bp_ops_cnt", stat_ops_o, 32'd5);
`endif
    ready_i = 1'b1;
    cnt = 0;
    while (idx < 6 && cnt < 20) begin
      step(acc);
      if (cnt < 8) acc_hist[cnt] = acc;
      cnt++;
      if (acc) begin
        idx++;
        if (idx < 6) set_op(4'(idx), 3'($urandom_range(0, 7)));
      end
    end
    check("bp_accept_all", idx, 6);
    check("bp_refill_wait", acc_hist[0], 1'b0);
    check("bp_refill_rise", acc_hist[1], 1'b1);
    drain();

    // Simultaneous accept and pop at one credit
    ready_i = 1'b0;
    v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(4'(i + 1), 3'($urandom_range(0, 7)));
      step(acc);
    end
    v_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ready_i = 1'b1;
    v_i = 1'b1;
    set_op(4'd7, 3'd1);
    step(acc);
    check("sim_accept", acc, 1'b1);
    ready_i = 1'b0;
    set_op(4'd8, 3'd2);
    step(acc);
    check("sim_credit_kept", acc, 1'b1);
    set_op(4'd9, 3'd3);
    step(acc);
    check("sim_credit_zero", acc, 1'b0);
    drain();

    // Streaming after a fresh reset
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    ready_i = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          set_op(4'(i), 3'($urandom_range(0, 7)));
          v_i = 1'b1;
          step(acc);
          check("stream_ready", acc, 1'b1);
        end
        v_i = 1'b0;
      end
      begin
        for (int i = 0; i < 104; i++) begin
          @(negedge clk);
          check("stream_vo", v_o, (i >= 3) && (i <= 102));
          @(posedge clk);
        end
      end
    join
    #1;
`ifdef MX_ALU_PIPE_STATS_EN
    check("stream_ops_cnt", stat_ops_o, 32'd100);
`endif
    drain();

    // Reset mid-flight: one FIFO entry, then three more ops in flight
    ready_i = 1'b0;
    v_i = 1'b1;
    set_op(4'd8, 3'd0);
    step(acc);
    v_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(4'(9 + i), 3'($urandom_range(0, 7)));
      step(acc);
    end
    set_op(4'd12, 3'd6);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", ready_o, 1'b0);
    check("rst_mid_v", v_o, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 3) check("rst_vo_clear", v_o, 1'b0);
      acc = v_i && ready_o;
      if (acc) begin
        sb_q.push_back(model(dtype_i, op_i, scalar_i, vec_a_i, vec_b_i, tag_i));
        cnt++;
      end
      @(posedge clk);
      #1;
      if (acc) set_op(4'(12 + cnt), 3'($urandom_range(0, 7)));
    end
    check("rst_refill_cnt", cnt, 4);
    drain();

`ifdef MX_ALU_PIPE_STATS_EN
    // Counter wrap
    force dut.stat_ops_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_ops_q;
    ready_i = 1'b1;
    v_i = 1'b1;
    set_op(4'd3, 3'd5);
    step(acc);
    v_i = 1'b0;
    check("ops_wrap", stat_ops_o, 32'd0);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
